// File: rtl/message_schedule_generator_pkg.sv
// Shared definitions for the SHA-2 message schedule: word/round pairings,
// sigma rotate/shift amounts per word width, and the index-width helper.
package message_schedule_generator_pkg;

  localparam int SHA256_WORD   = 32;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_WORD   = 64;
  localparam int SHA512_ROUNDS = 80;

  // Selectors into sigmaAmount: s0 = ROTR a ^ ROTR b ^ SHR c, same layout for s1.
  localparam int SIG0_ROT_A = 0;
  localparam int SIG0_ROT_B = 1;
  localparam int SIG0_SHR   = 2;
  localparam int SIG1_ROT_A = 3;
  localparam int SIG1_ROT_B = 4;
  localparam int SIG1_SHR   = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  function automatic int clogb2(input int depth);
    int bits;
    bits = 0;
    for (int v = depth - 1; v > 0; v = v >> 1) begin
      bits++;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

  function automatic int roundsFor(input int wordSize);
    return (wordSize == SHA512_WORD) ? SHA512_ROUNDS : SHA256_ROUNDS;
  endfunction

  function automatic int sigmaAmount(input int wordSize, input int sel);
    if (wordSize == SHA512_WORD) begin
      case (sel)
        SIG0_ROT_A: return 1;
        SIG0_ROT_B: return 8;
        SIG0_SHR:   return 7;
        SIG1_ROT_A: return 19;
        SIG1_ROT_B: return 61;
        default:    return 6;
      endcase
    end
    case (sel)
      SIG0_ROT_A: return 7;
      SIG0_ROT_B: return 18;
      SIG0_SHR:   return 3;
      SIG1_ROT_A: return 17;
      SIG1_ROT_B: return 19;
      default:    return 10;
    endcase
  endfunction

endpackage

// File: rtl/message_schedule_generator_sigma.sv
// Combinational small-sigma functions s0/s1 for the message schedule;
// rotate/shift amounts follow WORD_SIZE (SHA-256 or SHA-512).
module schedule_sigma
  import message_schedule_generator_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] i_x0,
  input  logic [WORD_SIZE-1:0] i_x1,
  output logic [WORD_SIZE-1:0] o_sigma0,
  output logic [WORD_SIZE-1:0] o_sigma1
);

  localparam int S0_RA = sigmaAmount(WORD_SIZE, SIG0_ROT_A);
  localparam int S0_RB = sigmaAmount(WORD_SIZE, SIG0_ROT_B);
  localparam int S0_SH = sigmaAmount(WORD_SIZE, SIG0_SHR);
  localparam int S1_RA = sigmaAmount(WORD_SIZE, SIG1_ROT_A);
  localparam int S1_RB = sigmaAmount(WORD_SIZE, SIG1_ROT_B);
  localparam int S1_SH = sigmaAmount(WORD_SIZE, SIG1_SHR);

  function automatic logic [WORD_SIZE-1:0] rotr(input logic [WORD_SIZE-1:0] x, input int n);
    return (x >> n) | (x << (WORD_SIZE - n));
  endfunction

  assign o_sigma0 = rotr(i_x0, S0_RA) ^ rotr(i_x0, S0_RB) ^ (i_x0 >> S0_SH);
  assign o_sigma1 = rotr(i_x1, S1_RA) ^ rotr(i_x1, S1_RB) ^ (i_x1 >> S1_SH);

endmodule

// File: rtl/message_schedule_generator.sv
// Message schedule responder: loads one 16-word block, expands it through a
// sliding 16-word window and serves W[t] / W[t+1] combinationally.
module message_schedule_generator
  import message_schedule_generator_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int ROUNDS      = roundsFor(WORD_SIZE),
  parameter int BLOCK_WORDS = 16,
  localparam int IDX_W      = clogb2(ROUNDS)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WORD_SIZE*BLOCK_WORDS-1:0] block_data,
  input  logic                           block_valid,
  output logic                           block_ready,
  input  logic                           clear,
  input  logic [IDX_W-1:0]               message_schedule_index,
  output logic [WORD_SIZE-1:0]           message_schedule_value,
  output logic                           schedule_ready,
  output logic                           schedule_done,
  output logic                           schedule_error
);

  localparam logic [IDX_W-1:0] LAST_T   = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] PENULT_T = IDX_W'(ROUNDS - 2);

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_window [BLOCK_WORDS];
  logic [IDX_W-1:0]     r_t;
  logic                 r_done;
  logic                 r_error;

  logic [IDX_W:0]       w_tPlusOne;
  logic                 w_run;
  logic                 w_lastT;
  logic                 w_hitCur;
  logic                 w_hitNext;
  logic                 w_advance;
  logic                 w_finalSeen;
  logic                 w_badIndex;
  logic [WORD_SIZE-1:0] w_sigma0;
  logic [WORD_SIZE-1:0] w_sigma1;
  logic [WORD_SIZE-1:0] w_newWord;

  schedule_sigma #(
    .WORD_SIZE(WORD_SIZE)
  ) u_sigma (
    .i_x0    (r_window[1]),
    .i_x1    (r_window[14]),
    .o_sigma0(w_sigma0),
    .o_sigma1(w_sigma1)
  );

  // A request for t+1 is only a legal step while t has not saturated.
  assign w_tPlusOne  = {1'b0, r_t} + (IDX_W+1)'(1);
  assign w_run       = (r_state == S_RUN);
  assign w_lastT     = (r_t == LAST_T);
  assign w_hitCur    = (message_schedule_index == r_t);
  assign w_hitNext   = ({1'b0, message_schedule_index} == w_tPlusOne) && !w_lastT;
  assign w_advance   = w_run && w_hitNext;
  assign w_finalSeen = w_run && !r_done && (message_schedule_index == LAST_T) &&
                       (w_lastT || (r_t == PENULT_T));
  assign w_badIndex  = w_run && !w_hitCur && !w_hitNext;
  assign w_newWord   = w_sigma1 + r_window[9] + w_sigma0 + r_window[0];

  assign block_ready    = (r_state == S_IDLE);
  assign schedule_ready = w_run;
  assign schedule_done  = r_done;
  assign schedule_error = r_error;

  always_comb begin
    message_schedule_value = '0;
    if (w_run) begin
      message_schedule_value = w_hitNext ? r_window[1] : r_window[0];
    end
  end

  // Clear takes priority over both block load and window advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      for (int k = 0; k < BLOCK_WORDS; k++) r_window[k] <= '0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      for (int k = 0; k < BLOCK_WORDS; k++) r_window[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (block_valid) begin
            r_state <= S_RUN;
            r_t     <= '0;
            for (int k = 0; k < BLOCK_WORDS; k++) begin
              r_window[k] <= block_data[WORD_SIZE*(BLOCK_WORDS-k)-1 -: WORD_SIZE];
            end
          end
        end
        S_RUN: begin
          if (w_badIndex) r_error <= 1'b1;
          if (r_done) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end else begin
            if (w_advance) begin
              for (int k = 0; k < BLOCK_WORDS-1; k++) r_window[k] <= r_window[k+1];
              r_window[BLOCK_WORDS-1] <= w_newWord;
              r_t <= r_t + IDX_W'(1);
            end
            if (w_finalSeen) r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_message_schedule_generator.sv
// Self-checking bench for message_schedule_generator: SHA-256 and SHA-512
// instances checked against a software schedule model via a scoreboard queue.
module tb_message_schedule_generator;

  typedef struct {
    int          idx;
    logic [63:0] expected;
    string       name;
  } vecT;

  vecT abcTable[6];

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [511:0]  blockData32  = '0;
  logic          blockValid32 = 1'b0;
  logic          clear32      = 1'b0;
  logic [5:0]    index32      = '0;
  logic [31:0]   value32;
  logic          blockReady32, schedReady32, done32, error32;

  logic [1023:0] blockData64  = '0;
  logic          blockValid64 = 1'b0;
  logic          clear64      = 1'b0;
  logic [6:0]    index64      = '0;
  logic [63:0]   value64;
  logic          blockReady64, schedReady64, done64, error64;

  int          checks = 0;
  int          errors = 0;
  int          doneEarly = 0;
  logic [63:0] wModel [80];
  logic [63:0] sbQ [$];

  message_schedule_generator #(.WORD_SIZE(32), .ROUNDS(64), .BLOCK_WORDS(16)) dut32 (
    .clock(clock), .reset(reset),
    .block_data(blockData32), .block_valid(blockValid32), .block_ready(blockReady32),
    .clear(clear32), .message_schedule_index(index32), .message_schedule_value(value32),
    .schedule_ready(schedReady32), .schedule_done(done32), .schedule_error(error32)
  );

  message_schedule_generator #(.WORD_SIZE(64), .ROUNDS(80), .BLOCK_WORDS(16)) dut64 (
    .clock(clock), .reset(reset),
    .block_data(blockData64), .block_valid(blockValid64), .block_ready(blockReady64),
    .clear(clear64), .message_schedule_index(index64), .message_schedule_value(value64),
    .schedule_ready(schedReady64), .schedule_done(done64), .schedule_error(error64)
  );

  always #5 clock = ~clock;

  // Reference SHA-2 small-sigma functions written from the standard.
  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic buildModel(input logic [1023:0] blk, input bit is64);
    logic [31:0] a32;
    logic [31:0] b32;
    logic [63:0] a64;
    logic [63:0] b64;
    for (int i = 0; i < 80; i++) wModel[i] = '0;
    for (int i = 0; i < 16; i++) begin
      if (is64) wModel[i] = blk[1023-64*i -: 64];
      else      wModel[i] = {32'b0, blk[511-32*i -: 32]};
    end
    for (int i = 16; i < (is64 ? 80 : 64); i++) begin
      if (is64) begin
        a64 = rotr64(wModel[i-15], 1) ^ rotr64(wModel[i-15], 8) ^ (wModel[i-15] >> 7);
        b64 = rotr64(wModel[i-2], 19) ^ rotr64(wModel[i-2], 61) ^ (wModel[i-2] >> 6);
        wModel[i] = b64 + wModel[i-7] + a64 + wModel[i-16];
      end else begin
        a32 = wModel[i-15][31:0];
        b32 = wModel[i-2][31:0];
        a32 = rotr32(a32, 7) ^ rotr32(a32, 18) ^ (a32 >> 3);
        b32 = rotr32(b32, 17) ^ rotr32(b32, 19) ^ (b32 >> 10);
        wModel[i] = {32'b0, b32 + wModel[i-7][31:0] + a32 + wModel[i-16][31:0]};
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setIndex(input bit is64, input int i);
    if (is64) index64 = 7'(i);
    else      index32 = 6'(i);
  endtask

  function automatic logic [63:0] readValue(input bit is64);
    return is64 ? value64 : {32'b0, value32};
  endfunction

  // Bits: {block_ready, schedule_ready, schedule_done, schedule_error}
  function automatic logic [3:0] readStatus(input bit is64);
    if (is64) return {blockReady64, schedReady64, done64, error64};
    return {blockReady32, schedReady32, done32, error32};
  endfunction

  // Loads a block; returns one cycle into RUN with t = 0.
  task automatic applyStimulus(input bit is64, input logic [1023:0] blk);
    logic [3:0] st;
    buildModel(blk, is64);
    tick();
    if (is64) begin
      blockData64  = blk;
      blockValid64 = 1'b1;
    end else begin
      blockData32  = blk[511:0];
      blockValid32 = 1'b1;
    end
    @(negedge clock);
    st = readStatus(is64);
    checkOutput("block_ready before load", 64'(st[3]), 64'd1);
    tick();
    blockValid32 = 1'b0;
    blockValid64 = 1'b0;
  endtask

  task automatic stepIndex(input bit is64, input int i, input bit useTable, input int hold);
    logic [63:0] expVal;
    logic [3:0]  st;
    setIndex(is64, i);
    sbQ.push_back(wModel[i]);
    @(negedge clock);
    expVal = sbQ.pop_front();
    checkOutput($sformatf("value idx %0d", i), readValue(is64), expVal);
    if (useTable && hold == 0) begin
      for (int k = 0; k < 6; k++) begin
        if (abcTable[k].idx == i) checkOutput(abcTable[k].name, readValue(is64), abcTable[k].expected);
      end
    end
    st = readStatus(is64);
    if (st[1]) doneEarly++;
    tick();
  endtask

  task automatic runSchedule(input bit is64, input logic [1023:0] blk, input bit randomHolds,
                             input bit useTable, input string tag);
    int         rounds;
    int         holds;
    logic [3:0] st;
    rounds    = is64 ? 80 : 64;
    doneEarly = 0;
    applyStimulus(is64, blk);
    for (int i = 0; i < rounds; i++) begin
      holds = (randomHolds && i < rounds - 1) ? int'($urandom_range(0, 3)) : 0;
      for (int h = 0; h <= holds; h++) stepIndex(is64, i, useTable, h);
    end
    @(negedge clock);
    st = readStatus(is64);
    checkOutput({tag, " done pulse"}, 64'(st[1]), 64'd1);
    checkOutput({tag, " ready during done"}, 64'(st[2]), 64'd1);
    checkOutput({tag, " last value"}, readValue(is64), wModel[rounds-1]);
    checkOutput({tag, " no early done"}, 64'(doneEarly), 64'd0);
    checkOutput({tag, " no error"}, 64'(st[0]), 64'd0);
    tick();
    @(negedge clock);
    st = readStatus(is64);
    checkOutput({tag, " idle block_ready"}, 64'(st[3]), 64'd1);
    checkOutput({tag, " idle sched_ready"}, 64'(st[2]), 64'd0);
    checkOutput({tag, " done single"}, 64'(st[1]), 64'd0);
    checkOutput({tag, " idle value"}, readValue(is64), 64'd0);
  endtask

  function automatic logic [1023:0] randomBlock();
    logic [1023:0] blk;
    for (int k = 0; k < 32; k++) blk[32*k +: 32] = $urandom();
    return blk;
  endfunction

  initial begin
    logic [1023:0] abc256;
    logic [1023:0] abc512;
    logic [1023:0] blk;
    logic [3:0]    st;

    abcTable[0] = '{0,  64'h61626380, "abc W0"};
    abcTable[1] = '{15, 64'h00000018, "abc W15"};
    abcTable[2] = '{16, 64'h61626380, "abc W16"};
    abcTable[3] = '{17, 64'h000F0000, "abc W17"};
    abcTable[4] = '{18, 64'h7DA86405, "abc W18"};
    abcTable[5] = '{19, 64'h600003C6, "abc W19"};

    abc256 = '0;
    abc256[511:480] = 32'h61626380;
    abc256[31:0]    = 32'h00000018;
    abc512 = '0;
    abc512[1023:960] = 64'h6162638000000000;
    abc512[63:0]     = 64'h18;

    // Reset state
    repeat (2) @(negedge clock);
    st = readStatus(1'b0);
    checkOutput("reset block_ready", 64'(st[3]), 64'd1);
    checkOutput("reset sched_ready", 64'(st[2]), 64'd0);
    checkOutput("reset done", 64'(st[1]), 64'd0);
    checkOutput("reset error", 64'(st[0]), 64'd0);
    checkOutput("reset value", readValue(1'b0), 64'd0);
    st = readStatus(1'b1);
    checkOutput("reset64 status", 64'(st), 64'h8);
    reset = 1'b1;

    $display("[TB] SHA-256 abc block");
    runSchedule(1'b0, abc256, 1'b0, 1'b1, "abc256");

    for (int r = 0; r < 3; r++) begin
      $display("[TB] random block %0d with holds", r);
      runSchedule(1'b0, randomBlock(), 1'b1, 1'b0, $sformatf("rand%0d", r));
    end

    $display("[TB] index jump and clear");
    applyStimulus(1'b0, abc256);
    for (int i = 0; i <= 5; i++) stepIndex(1'b0, i, 1'b0, 0);
    setIndex(1'b0, 9);
    @(negedge clock);
    checkOutput("error before jump edge", 64'(error32), 64'd0);
    tick();
    setIndex(1'b0, 5);
    @(negedge clock);
    checkOutput("error after jump", 64'(error32), 64'd1);
    checkOutput("value after jump", readValue(1'b0), wModel[5]);
    tick();
    @(negedge clock);
    checkOutput("error sticky", 64'(error32), 64'd1);
    tick();
    clear32 = 1'b1;
    tick();
    clear32 = 1'b0;
    @(negedge clock);
    st = readStatus(1'b0);
    checkOutput("clear block_ready", 64'(st[3]), 64'd1);
    checkOutput("clear sched_ready", 64'(st[2]), 64'd0);
    checkOutput("clear error", 64'(st[0]), 64'd0);

    $display("[TB] clear with block_valid in IDLE");
    tick();
    clear32      = 1'b1;
    blockValid32 = 1'b1;
    blockData32  = abc256[511:0];
    tick();
    clear32      = 1'b0;
    blockValid32 = 1'b0;
    @(negedge clock);
    st = readStatus(1'b0);
    checkOutput("clear+valid block_ready", 64'(st[3]), 64'd1);
    checkOutput("clear+valid sched_ready", 64'(st[2]), 64'd0);

    $display("[TB] reset mid-run");
    blk = randomBlock();
    applyStimulus(1'b0, blk);
    for (int i = 0; i <= 3; i++) stepIndex(1'b0, i, 1'b0, 0);
    setIndex(1'b0, 9);
    tick();
    @(negedge clock);
    checkOutput("error before reset", 64'(error32), 64'd1);
    tick();
    reset = 1'b0;
    #2;
    st = readStatus(1'b0);
    checkOutput("midrun reset block_ready", 64'(st[3]), 64'd1);
    checkOutput("midrun reset sched_ready", 64'(st[2]), 64'd0);
    checkOutput("midrun reset error", 64'(st[0]), 64'd0);
    checkOutput("midrun reset value", readValue(1'b0), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    setIndex(1'b0, 0);

    $display("[TB] SHA-512 abc block");
    runSchedule(1'b1, abc512, 1'b0, 1'b0, "abc512");
    runSchedule(1'b1, randomBlock(), 1'b1, 1'b0, "rand512");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
